// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: drives pc_addr to a combinational imem, captures
// {pc, instr, exc} into a small registered queue toward decode, and halts after a fault.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc_addr,
  input  logic [31:0] instruction,
  input  logic        exc_en,
  input  logic [3:0]  exc_code,
  input  logic [63:0] exc_val,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_exc,
  output logic [3:0]  out_exc_code,
  output logic [63:0] out_exc_val
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW:0] QMAX = QDEPTH[PW:0];
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef enum logic {RUN, HALT} state_t;

  state_t        state;
  logic [63:0]   fetch_pc;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;

  logic [63:0] q_pc    [QDEPTH];
  logic [31:0] q_instr [QDEPTH];
  logic        q_exc   [QDEPTH];
  logic [3:0]  q_code  [QDEPTH];
  logic [63:0] q_val   [QDEPTH];

  logic        pop, can_push, push;
  logic [31:0] e_instr;
  logic        e_exc;
  logic [3:0]  e_code;
  logic [63:0] e_val;

  assign pc_addr   = fetch_pc;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign can_push  = (count < QMAX) | pop;
  assign push      = (state == RUN) & can_push & ~redirect_en;

  // Local misalignment check outranks the imem-reported fault.
  always_comb begin
    e_instr = instruction;
    e_exc   = 1'b0;
    e_code  = '0;
    e_val   = '0;
    if (fetch_pc[1:0] != 2'b00) begin
      e_instr = NOP;
      e_exc   = 1'b1;
      e_val   = fetch_pc;
    end else if (exc_en) begin
      e_instr = NOP;
      e_exc   = 1'b1;
      e_code  = exc_code;
      e_val   = exc_val;
    end
  end

  always_comb begin
    out_pc       = '0;
    out_instr    = '0;
    out_exc      = 1'b0;
    out_exc_code = '0;
    out_exc_val  = '0;
    if (out_valid) begin
      out_pc       = q_pc[rd_ptr];
      out_instr    = q_instr[rd_ptr];
      out_exc      = q_exc[rd_ptr];
      out_exc_code = q_code[rd_ptr];
      out_exc_val  = q_val[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_pc[wr_ptr]    <= fetch_pc;
      q_instr[wr_ptr] <= e_instr;
      q_exc[wr_ptr]   <= e_exc;
      q_code[wr_ptr]  <= e_code;
      q_val[wr_ptr]   <= e_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      state    <= RUN;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect_en) begin
      fetch_pc <= redirect_pc;
      state    <= RUN;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase
      if (push) begin
        if (e_exc) state    <= HALT;
        else       fetch_pc <= fetch_pc + 64'd4;
      end
    end
  end

endmodule
